// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown_timer block.
//   t_cd_state      - controller state encoding (2 bits)
//   CD_MIN_PRESCALE - smallest legal clock-cycles-per-tick value
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } t_cd_state;

    localparam int CD_MIN_PRESCALE = 1;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler for countdown_timer. Emits a one-cycle tick every
// PRESCALE enabled cycles; the phase is held while en is low.
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active low
//   en   - advance the prescaler this cycle
//   clr  - restart the prescaler at phase 0 (wins over en)
//   tick - high in the enabled cycle where the phase is PRESCALE-1
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // PRESCALE=1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, abort and auto-reload.
//   clk       - system clock, rising edge
//   rst       - asynchronous reset, active low
//   load_val  - start value, sampled when a start is accepted
//   start     - begin countdown from IDLE or DONE
//   pause     - freeze count and prescaler while high
//   abort     - return to IDLE from any state
//   reload_en - at terminal count, reload instead of stopping
//   count     - current count
//   busy      - high in RUN or PAUSE
//   underflow - one-cycle pulse per terminal count
//   done      - high in DONE until start or abort
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             underflow,
    output logic             done
);

    if (PRESCALE < CD_MIN_PRESCALE) begin : g_bad_prescale
        $error("countdown_timer: PRESCALE must be >= %0d", CD_MIN_PRESCALE);
    end

    t_cd_state        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_busy, r_underflow, w_underflow_nxt;
    logic             r_done, w_done_nxt;
    logic             w_tick, w_tick_en, w_tick_clr;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_tick_en),
        .clr  (w_tick_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_reload_nxt    = r_reload;
        w_underflow_nxt = 1'b0;
        w_done_nxt      = r_done;
        w_tick_en       = 1'b0;
        w_tick_clr      = 1'b0;

        if (abort) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
            w_tick_clr  = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_count_nxt  = load_val;
                        w_reload_nxt = load_val;
                        w_tick_clr   = 1'b1;
                        if (load_val == '0) begin
                            w_state_nxt     = DONE;
                            w_underflow_nxt = 1'b1;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                            w_done_nxt  = 1'b0;
                        end
                    end
                end
                RUN, PAUSE: begin
                    if (pause) begin
                        w_state_nxt = PAUSE;
                    end else begin
                        // The cycle that leaves PAUSE counts as a run cycle,
                        // so every paused cycle delays the terminal count by
                        // exactly one cycle.
                        w_state_nxt = RUN;
                        w_tick_en   = 1'b1;
                        if (w_tick) begin
                            if (r_count > WIDTH'(1)) begin
                                w_count_nxt = r_count - 1'b1;
                            end else if (reload_en) begin
                                w_count_nxt     = r_reload;
                                w_underflow_nxt = 1'b1;
                            end else begin
                                w_count_nxt     = '0;
                                w_underflow_nxt = 1'b1;
                                w_done_nxt      = 1'b1;
                                w_state_nxt     = DONE;
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_reload    <= '0;
            r_busy      <= 1'b0;
            r_underflow <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_reload    <= w_reload_nxt;
            r_busy      <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
            r_underflow <= w_underflow_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign count     = r_count;
    assign busy      = r_busy;
    assign underflow = r_underflow;
    assign done      = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven checks on a PRESCALE=1 instance with a
// scoreboard queue, plus hand-written sequences for prescaled timing and
// asynchronous reset on a PRESCALE=4 instance.
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0, pause = 1'b0, abort = 1'b0, reload_en = 1'b0;
    logic [W-1:0] c1, c4;
    logic         b1, u1, d1, b4, u4, d4;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load_val(load_val), .start(start), .pause(pause),
        .abort(abort), .reload_en(reload_en),
        .count(c1), .busy(b1), .underflow(u1), .done(d1)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .load_val(load_val), .start(start), .pause(pause),
        .abort(abort), .reload_en(reload_en),
        .count(c4), .busy(b4), .underflow(u4), .done(d4)
    );

    typedef struct {
        logic         st;
        logic [W-1:0] lv;
        logic         pa, ab, re;
        logic [W-1:0] cnt;
        logic         bsy, uf, dn;
        string        nm;
    } vec_t;

    typedef struct {
        logic [W-1:0] cnt;
        logic         bsy, uf, dn;
        string        nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic st, logic [W-1:0] lv, logic pa, logic ab, logic re,
                                logic [W-1:0] cnt, logic bsy, logic uf, logic dn, string nm);
        vec_t v;
        v.st = st; v.lv = lv; v.pa = pa; v.ab = ab; v.re = re;
        v.cnt = cnt; v.bsy = bsy; v.uf = uf; v.dn = dn; v.nm = nm;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic st, logic [W-1:0] lv, logic pa, logic ab, logic re);
        @(negedge clk);
        start = st; load_val = lv; pause = pa; abort = ab; reload_en = re;
    endtask

    initial begin
        exp_t e;

        // Reset asserted before any clock edge.
        #2 rst = 1'b0;
        #2;
        chk("reset count", 32'(c1), 0);
        chk("reset busy", 32'(b1), 0);
        chk("reset underflow", 32'(u1), 0);
        chk("reset done", 32'(d1), 0);
        @(negedge clk) rst = 1'b1;

        //               st lv pa ab re  cnt bsy uf dn
        // basic count from 5
        tbl.push_back(mk(1, 5, 0, 0, 0,  5, 1, 0, 0, "ld5 start"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  4, 1, 0, 0, "ld5 c4"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  3, 1, 0, 0, "ld5 c3"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  2, 1, 0, 0, "ld5 c2"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0, "ld5 c1"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1, "ld5 terminal"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, "ld5 done hold"));
        // load 0 from DONE: immediate terminal
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 1, "ld0 start"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, "ld0 after"));
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0, "abort from done"));
        // pause for 3 cycles after the 2nd decrement
        tbl.push_back(mk(1, 6, 0, 0, 0,  6, 1, 0, 0, "pause start"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  5, 1, 0, 0, "pause c5"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  4, 1, 0, 0, "pause c4"));
        tbl.push_back(mk(0, 0, 1, 0, 0,  4, 1, 0, 0, "pause hold1"));
        tbl.push_back(mk(0, 0, 1, 0, 0,  4, 1, 0, 0, "pause hold2"));
        tbl.push_back(mk(0, 0, 1, 0, 0,  4, 1, 0, 0, "pause hold3"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  3, 1, 0, 0, "pause c3"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  2, 1, 0, 0, "pause c2"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0, "pause c1"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1, "pause terminal"));
        // start during RUN is ignored
        tbl.push_back(mk(1, 3, 0, 0, 0,  3, 1, 0, 0, "run start"));
        tbl.push_back(mk(1, 9, 0, 0, 0,  2, 1, 0, 0, "restart ignored"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0, "run c1"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1, "run terminal"));
        // auto-reload
        tbl.push_back(mk(1, 2, 0, 0, 1,  2, 1, 0, 0, "rl start"));
        tbl.push_back(mk(0, 0, 0, 0, 1,  1, 1, 0, 0, "rl c1"));
        tbl.push_back(mk(0, 0, 0, 0, 1,  2, 1, 1, 0, "rl wrap1"));
        tbl.push_back(mk(0, 0, 0, 0, 1,  1, 1, 0, 0, "rl c1b"));
        tbl.push_back(mk(0, 0, 0, 0, 1,  2, 1, 1, 0, "rl wrap2"));
        tbl.push_back(mk(0, 0, 0, 1, 1,  0, 0, 0, 0, "rl abort"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, "rl idle"));
        // start and abort together: abort wins
        tbl.push_back(mk(1, 5, 0, 1, 0,  0, 0, 0, 0, "start+abort"));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, "start+abort idle"));

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].lv, tbl[i].pa, tbl[i].ab, tbl[i].re);
            e.cnt = tbl[i].cnt; e.bsy = tbl[i].bsy; e.uf = tbl[i].uf; e.dn = tbl[i].dn;
            e.nm = tbl[i].nm;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, " count"}, 32'(c1), 32'(e.cnt));
                chk({e.nm, " busy"}, 32'(b1), 32'(e.bsy));
                chk({e.nm, " underflow"}, 32'(u1), 32'(e.uf));
                chk({e.nm, " done"}, 32'(d1), 32'(e.dn));
            end
        end

        // PRESCALE=4, load 3: count steps every 4 cycles, terminal 12 edges
        // after the start edge.
        drive(0, 0, 0, 1, 0);
        drive(1, 3, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) begin
                drive(0, 0, 0, 0, 0);
                @(posedge clk);
                #1;
            end
            chk($sformatf("p4 count k=%0d", k), 32'(c4), (k >= 12) ? 0 : 3 - k / 4);
            chk($sformatf("p4 underflow k=%0d", k), 32'(u4), (k == 12) ? 1 : 0);
            chk($sformatf("p4 busy k=%0d", k), 32'(b4), (k < 12) ? 1 : 0);
            chk($sformatf("p4 done k=%0d", k), 32'(d4), (k >= 12) ? 1 : 0);
        end

        // Asynchronous reset mid-count.
        drive(1, 9, 0, 0, 0);
        @(posedge clk);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre-reset count", 32'(c1), 7);
        #2 rst = 1'b0;
        #1;
        chk("async rst count", 32'(c1), 0);
        chk("async rst busy", 32'(b1), 0);
        chk("async rst underflow", 32'(u1), 0);
        chk("async rst done", 32'(d1), 0);
        chk("async rst p4 busy", 32'(b4), 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) begin
            drive(0, 0, 0, 0, 0);
            @(posedge clk);
        end
        #1;
        chk("post-reset idle count", 32'(c1), 0);
        chk("post-reset idle busy", 32'(b1), 0);
        chk("post-reset idle done", 32'(d1), 0);
        drive(1, 2, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post-reset start count", 32'(c1), 2);
        chk("post-reset start busy", 32'(b1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
